// File: rtl/rgb_to_grayscale.sv
// rgb_to_grayscale: 3-stage fixed-point luma pipeline for a 24-bit RGB pixel
// stream, with vs/hs/de delayed to match and a per-frame geometry checker
// operating on the delayed (output-side) sync signals.
module rgb_to_grayscale #(
  parameter int         HR     = 800,
  parameter int         VR     = 300,
  parameter logic [7:0] COEF_R = 8'd77,
  parameter logic [7:0] COEF_G = 8'd150,
  parameter logic [7:0] COEF_B = 8'd29
) (
  input  logic        hdmi_clk,
  input  logic        hdmi_rst_n,
  input  logic        hdmi_vs_in,
  input  logic        hdmi_hs_in,
  input  logic        hdmi_de_in,
  input  logic [23:0] rgb_data,
  output logic        hdmi_vs,
  output logic        hdmi_hs,
  output logic        hdmi_de,
  output logic [7:0]  grayscale_data,
  output logic        frame_done,
  output logic        geom_err,
  output logic [15:0] line_count,
  output logic [15:0] pixel_count
);

  localparam logic [15:0] HR_W    = 16'(HR);
  localparam logic [15:0] VR_W    = 16'(VR);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [15:0] prod_r, prod_g, prod_b;
  logic [17:0] sum;
  logic        vs_d1, vs_d2, hs_d1, hs_d2, de_d1, de_d2;
  logic [7:0]  sat;

  // Clamp the 10-bit integer part of the rounded sum to 8 bits
  assign sat = (|sum[17:16]) ? 8'hFF : sum[15:8];

  // Stage 1: weighted products of the three colour channels
  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      prod_r <= 16'd0;
      prod_g <= 16'd0;
      prod_b <= 16'd0;
    end else begin
      prod_r <= {8'd0, rgb_data[23:16]} * {8'd0, COEF_R};
      prod_g <= {8'd0, rgb_data[15:8]}  * {8'd0, COEF_G};
      prod_b <= {8'd0, rgb_data[7:0]}   * {8'd0, COEF_B};
    end
  end

  // Stage 2: sum of products plus half an LSB of the Q0.8 result for rounding
  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      sum <= 18'd0;
    end else begin
      sum <= {2'b00, prod_r} + {2'b00, prod_g} + {2'b00, prod_b} + 18'd128;
    end
  end

  // Stage 3: saturated luma, forced to zero outside active video
  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      grayscale_data <= 8'd0;
    end else begin
      grayscale_data <= de_d2 ? sat : 8'd0;
    end
  end

  // Sync shift register matching the 3-cycle datapath latency; the output vs
  // idles high so downstream logic sees blanking while in reset
  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      vs_d1   <= 1'b0;
      vs_d2   <= 1'b0;
      hdmi_vs <= 1'b1;
      hs_d1   <= 1'b0;
      hs_d2   <= 1'b0;
      hdmi_hs <= 1'b0;
      de_d1   <= 1'b0;
      de_d2   <= 1'b0;
      hdmi_de <= 1'b0;
    end else begin
      vs_d1   <= hdmi_vs_in;
      vs_d2   <= vs_d1;
      hdmi_vs <= vs_d2;
      hs_d1   <= hdmi_hs_in;
      hs_d2   <= hs_d1;
      hdmi_hs <= hs_d2;
      de_d1   <= hdmi_de_in;
      de_d2   <= de_d1;
      hdmi_de <= de_d2;
    end
  end

  // ---------------------------------------------------------------------------
  // Geometry checker
  // Edges are detected between the current output-side value (hdmi_vs/hdmi_de)
  // and the value about to be loaded (vs_d2/de_d2), so every registered result
  // appears on the very cycle the edge becomes visible on the outputs.
  // ---------------------------------------------------------------------------
  logic        armed;
  logic        vs_live;   // a genuine vs high has reached stage 2 since reset
  logic        err_flag;
  logic [15:0] line_cnt;
  logic [15:0] pix_cnt;

  logic        frame_start, frame_end, line_end;
  logic        err_next;
  logic [15:0] line_cnt_next;

  // The vs high forced by reset is not a real blanking interval, so the fall
  // that follows it must not arm the checker
  assign frame_start = hdmi_vs & ~vs_d2 & vs_live;
  assign frame_end   = ~hdmi_vs & vs_d2 & armed;
  assign line_end    = hdmi_de & ~de_d2;

  // Next line counter / error flag: frame start clears first, a line end is
  // then counted, so a line ending together with vs rising is included
  always_comb begin
    err_next      = err_flag;
    line_cnt_next = line_cnt;
    if (frame_start) begin
      err_next      = 1'b0;
      line_cnt_next = 16'd0;
    end
    if (line_end) begin
      if (pix_cnt != HR_W) begin
        err_next = 1'b1;
      end
      if (line_cnt_next != CNT_MAX) begin
        line_cnt_next = line_cnt_next + 16'd1;
      end
    end
    if (de_d2 && vs_d2) begin
      err_next = 1'b1;
    end
  end

  // Frame/line bookkeeping and reported status
  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      armed       <= 1'b0;
      vs_live     <= 1'b0;
      err_flag    <= 1'b0;
      line_cnt    <= 16'd0;
      pix_cnt     <= 16'd0;
      frame_done  <= 1'b0;
      geom_err    <= 1'b0;
      line_count  <= 16'd0;
      pixel_count <= 16'd0;
    end else begin
      vs_live    <= vs_live | vs_d2;
      err_flag   <= err_next;
      line_cnt   <= line_cnt_next;
      frame_done <= frame_end;

      if (frame_start) begin
        armed <= 1'b1;
      end else if (frame_end) begin
        armed <= 1'b0;
      end

      if (line_end) begin
        pixel_count <= pix_cnt;
        pix_cnt     <= 16'd0;
      end else if (de_d2 && (pix_cnt != CNT_MAX)) begin
        pix_cnt <= pix_cnt + 16'd1;
      end

      if (frame_end) begin
        line_count <= line_cnt_next;
        geom_err   <= err_next | (line_cnt_next != VR_W);
      end
    end
  end

endmodule

// File: doc/rgb_to_grayscale.md
Name: rgb_to_grayscale

Overview:
- Synthesizable luma stage feeding the grayscale PGM capture/consumer stage.
- Converts the 24-bit RGB HDMI pixel stream into 8-bit grayscale using fixed-point weighted coefficients with rounding and saturation.
- Delays vs/hs/de to stay aligned with the pixel data.
- Checks frame geometry against the expected resolution and reports per-frame status.

Parameters:
HR, 800, expected active pixels per line
VR, 300, expected active lines per frame
COEF_R, 77, red weight (unsigned 8-bit, Q0.8)
COEF_G, 150, green weight (unsigned 8-bit, Q0.8)
COEF_B, 29, blue weight (unsigned 8-bit, Q0.8)

Ports:
hdmi_clk  in  1  pixel clock; all logic on rising edge
hdmi_rst_n  in  1  asynchronous active-low reset
hdmi_vs_in  in  1  vertical sync; high = vertical blanking pulse
hdmi_hs_in  in  1  horizontal sync, passed through
hdmi_de_in  in  1  data enable, active pixel when high
rgb_data  in  24  {R[23:16], G[15:8], B[7:0]}
hdmi_vs  out  1  vs_in delayed 3 cycles
hdmi_hs  out  1  hs_in delayed 3 cycles
hdmi_de  out  1  de_in delayed 3 cycles
grayscale_data  out  8  luma, aligned with hdmi_de
frame_done  out  1  one-cycle pulse at end of checked frame
geom_err  out  1  result of last completed frame; 1 = geometry mismatch
line_count  out  16  active lines counted in last completed frame
pixel_count  out  16  DE pixels in last completed line

Behaviour:
- Reset: asynchronous assert / synchronous release.
  - All outputs and pipeline registers go to 0, except hdmi_vs, which resets to 1 (blanking).
  - armed = 0.
- Pipeline: fixed latency of 3 cycles; no stalls, no back-pressure.
  - S1: register the three 16-bit products R*COEF_R, G*COEF_G, B*COEF_B.
  - S2: register the 18-bit sum plus 128 (rounding constant).
  - S3: take sum[17:8] (10 bits); if greater than 255, output 255, else output the low 8 bits.
  - vs/hs/de travel through a matching 3-stage shift.
  - grayscale_data is 0 whenever the delayed de is 0.
- Geometry checker runs on the delayed (output-side) signals.
  - frame start = falling edge of hdmi_vs. Sets armed = 1, clears the line counter and the internal error flag.
  - line end = falling edge of hdmi_de.
    - Latch the pixel counter into pixel_count.
    - If the count is not HR, set the internal error flag.
    - Increment the line counter; it saturates at 0xFFFF.
  - Pixel counter clears after the line end and saturates at 0xFFFF.
  - DE high while hdmi_vs is high sets the internal error flag (blanking violation).
  - frame end = rising edge of hdmi_vs while armed = 1.
    - If the line counter is not VR, set the error.
    - Copy the line counter into line_count and the error flag into geom_err.
    - Pulse frame_done for 1 cycle, on the same cycle hdmi_vs is first seen high.
    - Clear armed.
- Rising edge of hdmi_vs while armed = 0 (startup or post-reset partial frame): no frame_done, no update.
- Simultaneous DE falling edge and VS rising edge: the line is counted first, then the frame-end check includes that line.
- Reset mid-frame: all counters clear; the partial frame after release is never reported.
- geom_err, line_count and pixel_count hold their values until overwritten.

Test Plan:
- R=G=B=200 on a single DE pixel -> grayscale_data=200 exactly 3 cycles later with hdmi_de=1; 0xFFFFFF -> 255; 0x000000 -> 0.
- Primaries 0xFF0000, 0x00FF00, 0x0000FF -> 77, 149, 29 respectively. Back-to-back pixels give back-to-back outputs with no bubbles.
- Override COEF_R=COEF_G=COEF_B=255, input 0xFFFFFF -> saturates to 255, not 762 mod 256 (=250).
- Full 800x300 frame framed by VS -> frame_done pulses once, geom_err=0, line_count=300, pixel_count=800.
- Frame with one 799-pixel line, then a frame of 299 good lines -> geom_err=1 after each; pixel_count=799 after the short line. A following correct frame -> geom_err=0.
- Assert hdmi_rst_n low mid-frame for 2 cycles, then resume -> all outputs 0 (hdmi_vs=1), no frame_done at the next VS rise. The next full frame reports normally.
